// File: rtl/ascon_perm_core.sv
// Iterative Ascon permutation: UNROLL rounds per clock, runtime round count,
// valid/ready handshake on both the request and the result side.
module ascon_perm_core #(
    parameter int unsigned UNROLL    = 1,
    parameter int unsigned RND_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [319:0]         state_i,
    input  logic [RND_WIDTH-1:0] rnd_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [319:0]         state_o,
    output logic                 err_o,
    output logic                 busy_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be 1 or 2");
    end

    localparam logic [RND_WIDTH-1:0] STEP    = RND_WIDTH'(UNROLL);
    localparam logic [RND_WIDTH-1:0] MAX_RND = RND_WIDTH'(12);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e                 fsm_q;
    logic [319:0]         st_q;
    logic [319:0]         st_next;
    logic [RND_WIDTH-1:0] ci_q;
    logic [RND_WIDTH-1:0] rem_q;
    logic                 err_q;
    logic                 req_bad;

    function automatic logic [7:0] rnd_const(input logic [3:0] idx);
        case (idx)
            4'd0: return 8'hf0;  4'd1: return 8'he1;  4'd2:  return 8'hd2;  4'd3:  return 8'hc3;
            4'd4: return 8'hb4;  4'd5: return 8'ha5;  4'd6:  return 8'h96;  4'd7:  return 8'h87;
            4'd8: return 8'h78;  4'd9: return 8'h69;  4'd10: return 8'h5a;  4'd11: return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
            5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
            5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
        logic [63:0] x [5];
        logic [4:0]  col;
        for (int unsigned i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        x[2][7:0] = x[2][7:0] ^ rc;
        // Bit-sliced substitution: column j across the five words, x0 as MSB.
        for (int unsigned j = 0; j < 64; j++) begin
            col = sbox({x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]});
            {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]} = col;
        end
        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    always_comb begin
        st_next = st_q;
        for (int unsigned r = 0; r < UNROLL; r++) begin
            st_next = ascon_round(st_next, rnd_const(4'(ci_q + RND_WIDTH'(r))));
        end
    end

    always_comb begin
        req_bad = (rnd_i == '0) || (rnd_i > MAX_RND) || ((UNROLL == 2) && rnd_i[0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            ci_q  <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        st_q  <= state_i;
                        ci_q  <= MAX_RND - rnd_i;
                        rem_q <= rnd_i;
                        err_q <= req_bad;
                        fsm_q <= req_bad ? DONE : RUN;
                    end
                end
                RUN: begin
                    st_q  <= st_next;
                    ci_q  <= ci_q + STEP;
                    rem_q <= rem_q - STEP;
                    if (rem_q == STEP) fsm_q <= DONE;
                end
                DONE: begin
                    if (out_ready_i) fsm_q <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign busy_o      = (fsm_q == RUN);
    assign out_valid_o = (fsm_q == DONE);
    assign state_o     = st_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Directed/randomized bench for ascon_perm_core with UNROLL=1 (index 0) and
// UNROLL=2 (index 1) instances, checked against a bit-sliced reference model.
module tb_ascon_perm_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid [2];
    logic         in_ready [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [319:0] state_out [2];
    logic         err [2];
    logic         busy [2];
    logic [319:0] state_in = '0;
    logic [3:0]   rnd_in = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ascon_perm_core #(.UNROLL(1), .RND_WIDTH(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .state_i(state_in), .rnd_i(rnd_in), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .state_o(state_out[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    ascon_perm_core #(.UNROLL(2), .RND_WIDTH(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .state_i(state_in), .rnd_i(rnd_in), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .state_o(state_out[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference permutation in the boolean (bit-sliced) form of the Ascon S-box.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int i = 12 - rounds; i < 12; i++) begin
            x2 = x2 ^ 64'((15 - i) * 16 + i);
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
            x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
            x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
            x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
            x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns cycles from the accept edge (counted as 1) to out_valid.
    task automatic issue(input int u, input logic [319:0] st, input int rnd, input bit toggle,
                         output int lat, output logic busy_seen);
        state_in    = st;
        rnd_in      = 4'(rnd);
        in_valid[u] = 1'b1;
        check("in_ready before accept", 320'(in_ready[u]), 320'(1));
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        busy_seen   = busy[u];
        lat         = 1;
        while (!out_valid[u] && lat < 40) begin
            if (toggle) begin
                state_in = rand_state();
                rnd_in   = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out(input int u);
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        check("out_valid after handshake", 320'(out_valid[u]), 320'(0));
        check("in_ready after handshake", 320'(in_ready[u]), 320'(1));
    endtask

    task automatic run_case(input int u, input logic [319:0] st, input int rnd, input bit toggle,
                            input string tag);
        int   lat;
        logic bsy;
        bit   legal;
        legal = (rnd >= 1) && (rnd <= 12) && (rnd % (u + 1) == 0);
        issue(u, st, rnd, toggle, lat, bsy);
        check($sformatf("%s latency", tag), 320'(lat), 320'(legal ? rnd / (u + 1) + 1 : 1));
        check($sformatf("%s busy", tag), 320'(bsy), 320'(legal));
        check($sformatf("%s state", tag), state_out[u], legal ? ref_perm(st, rnd) : st);
        check($sformatf("%s err", tag), 320'(err[u]), 320'(!legal));
        release_out(u);
    endtask

    task automatic check_reset_vals(input int u, input string tag);
        check($sformatf("%s in_ready", tag), 320'(in_ready[u]), 320'(1));
        check($sformatf("%s out_valid", tag), 320'(out_valid[u]), 320'(0));
        check($sformatf("%s busy", tag), 320'(busy[u]), 320'(0));
        check($sformatf("%s err", tag), 320'(err[u]), 320'(0));
        check($sformatf("%s state", tag), state_out[u], '0);
    endtask

    initial begin
        logic [319:0] st, held;
        int           lat, rnd;
        logic         bsy, held_err;

        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(0, "reset u1");
        check_reset_vals(1, "reset u2");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case(0, {64'h80400c0600000000, 256'h0}, 12, 1'b0, "pa iv u1");
        run_case(1, {64'h80400c0600000000, 256'h0}, 12, 1'b0, "pa iv u2");
        run_case(1, rand_state(), 6, 1'b0, "pb6 u2");
        run_case(1, rand_state(), 8, 1'b0, "pb8 u2");

        for (int i = 0; i < 6; i++) run_case(0, rand_state(), int'($urandom_range(1, 12)), 1'b0, "rand u1");
        for (int i = 0; i < 4; i++) run_case(1, rand_state(), 2 * int'($urandom_range(1, 6)), 1'b0, "rand u2");
        run_case(0, rand_state(), 1, 1'b0, "min rnd u1");

        run_case(1, rand_state(), 0, 1'b0, "illegal 0 u2");
        run_case(1, rand_state(), 13, 1'b0, "illegal 13 u2");
        run_case(1, rand_state(), 7, 1'b0, "illegal 7 u2");
        run_case(0, rand_state(), 0, 1'b0, "illegal 0 u1");
        run_case(0, rand_state(), 15, 1'b0, "illegal 15 u1");

        run_case(1, rand_state(), 10, 1'b1, "toggle u2");
        run_case(0, rand_state(), 5, 1'b1, "toggle u1");

        // Backpressure: result held for 20 cycles while new requests are offered.
        st = rand_state();
        issue(1, st, 8, 1'b0, lat, bsy);
        check("bp latency", 320'(lat), 320'(5));
        held     = state_out[1];
        held_err = err[1];
        for (int i = 0; i < 20; i++) begin
            in_valid[1] = i[0];
            state_in    = rand_state();
            rnd_in      = 4'($urandom_range(1, 6) * 2);
            @(posedge clk); #1;
            check("bp state stable", state_out[1], held);
            check("bp err stable", 320'(err[1]), 320'(held_err));
            check("bp in_ready low", 320'(in_ready[1]), 320'(0));
            check("bp out_valid high", 320'(out_valid[1]), 320'(1));
        end
        in_valid[1] = 1'b0;
        check("bp result", state_out[1], ref_perm(st, 8));
        release_out(1);

        // Asynchronous reset in the 5th RUN cycle of a 12-round request.
        state_in    = rand_state();
        rnd_in      = 4'd12;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun busy", 320'(busy[0]), 320'(1));
        rst_n = 1'b0;
        #1;
        check_reset_vals(0, "midrun reset u1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(0, rand_state(), 12, 1'b0, "after reset u1");
        rnd = 12;
        run_case(1, rand_state(), rnd, 1'b0, "after reset u2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
